// File: rtl/miner_pkg.sv
// Shared constants, FSM state encoding and helpers for the miner host controller.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package miner_pkg;

  localparam logic [7:0] CMD_JOB     = 8'h01;
  localparam logic [7:0] CMD_READ    = 8'h02;
  localparam logic [7:0] SYNC_BYTE   = 8'hA5;
  localparam int         JOB_BYTES   = 80;
  localparam int         NONCE_BYTES = 8;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CMD,
    ST_PAYLOAD,
    ST_CHK,
    ST_NS_LOAD,
    ST_TX_STAT,
    ST_TX_BYTE,
    ST_NS_SHIFT
  } state_e;

  // Error counter increment that sticks at all-ones.
  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/strobe_gen.sv
// Registered data-then-strobe delay line: data captured on load_i, strobe two cycles later.
// Latency: data_o valid 1 cycle after load_i, load_o high for exactly the 2nd cycle after load_i.
// Backpressure: none; load_i must be spaced at least 3 cycles apart.
//
// Ports:
//   clk, rst          clock, asynchronous active-high reset
//   data_i, load_i    byte and its capture request
//   data_o, load_o    registered byte and its delayed, glitch-free strobe
module strobe_gen (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] data_i,
  input  logic       load_i,
  output logic [7:0] data_o,
  output logic       load_o
);

  logic [7:0] data_q;
  logic       pend_q;
  logic       load_q;

  // The one-cycle gap between data and strobe gives the edge-clocked
  // shift register a full cycle of setup on its data input.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_q <= 8'h00;
      pend_q <= 1'b0;
      load_q <= 1'b0;
    end else begin
      pend_q <= load_i;
      load_q <= pend_q;
      if (load_i) data_q <= data_i;
    end
  end

  assign data_o = data_q;
  assign load_o = load_q;

endmodule

// File: rtl/miner_host_ctrl.sv
// Host command framer: SYNC/CMD/payload/CHK frames drive job and nonce shift registers.
// Latency: sr_load 2 cycles after payload byte; job_valid 1 cycle after good CHK; ns_load 1 cycle after read CHK.
// Backpressure: rx has none (bytes >= 3 cycles apart); tx holds tx_valid/tx_data until tx_ready.
//
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   rx_data, rx_valid        byte stream from the UART receiver
//   tx_data, tx_valid, tx_ready  response byte stream to the UART transmitter
//   sr_data, sr_load, sr_rst job shift register byte, shift strobe, clear pulse
//   job_valid                job register holds a complete checksum-good job
//   found                    hasher result-valid level
//   ns_load, ns_out, ns_data nonce register load strobe, shift strobe, output byte
//   err_cnt                  saturating count of checksum errors and timeouts
module miner_host_ctrl #(
  parameter int         JOB_BYTES      = miner_pkg::JOB_BYTES,
  parameter int         NONCE_BYTES    = miner_pkg::NONCE_BYTES,
  parameter logic [7:0] SYNC_BYTE      = miner_pkg::SYNC_BYTE,
  parameter int         TIMEOUT_CYCLES = 1_000_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] rx_data,
  input  logic       rx_valid,
  output logic [7:0] tx_data,
  output logic       tx_valid,
  input  logic       tx_ready,
  output logic [7:0] sr_data,
  output logic       sr_load,
  output logic       sr_rst,
  output logic       job_valid,
  input  logic       found,
  output logic       ns_load,
  output logic       ns_out,
  input  logic [7:0] ns_data,
  output logic [7:0] err_cnt
);

  import miner_pkg::*;

  localparam int PW = (JOB_BYTES > 1) ? $clog2(JOB_BYTES) : 1;
  localparam int NW = (NONCE_BYTES > 1) ? $clog2(NONCE_BYTES) : 1;
  localparam int TW = $clog2(TIMEOUT_CYCLES);
  localparam logic [TW-1:0] TMO_LAST  = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [PW-1:0] PAY_LAST  = PW'(JOB_BYTES - 1);
  localparam logic [NW-1:0] NONCE_LAST = NW'(NONCE_BYTES - 1);

  state_e        state_q;
  logic [7:0]    chk_q;
  logic          is_job_q;
  logic [PW-1:0] pay_cnt_q;
  logic [NW-1:0] nleft_q;
  logic [TW-1:0] tmo_q;
  logic [7:0]    err_q;
  logic [7:0]    tx_data_q;
  logic          tx_valid_q;
  logic          sr_rst_q;
  logic          job_valid_q;
  logic          ns_load_q;
  logic          ns_out_q;
  logic          found_l_q;

  logic in_frame, tmo_hit, found_clr, found_l_d, sg_load;

  assign in_frame  = (state_q == ST_CMD) || (state_q == ST_PAYLOAD) || (state_q == ST_CHK);
  assign tmo_hit   = in_frame && !rx_valid && (tmo_q == TMO_LAST);
  // Clear happens on the last shift of a read; a concurrent found wins.
  assign found_clr = (state_q == ST_NS_SHIFT) && (nleft_q == '0);
  assign found_l_d = found || (found_l_q && !found_clr);
  assign sg_load   = (state_q == ST_PAYLOAD) && rx_valid;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      chk_q       <= 8'h00;
      is_job_q    <= 1'b0;
      pay_cnt_q   <= '0;
      nleft_q     <= '0;
      tmo_q       <= '0;
      err_q       <= 8'h00;
      tx_data_q   <= 8'h00;
      tx_valid_q  <= 1'b0;
      sr_rst_q    <= 1'b0;
      job_valid_q <= 1'b0;
      ns_load_q   <= 1'b0;
      ns_out_q    <= 1'b0;
      found_l_q   <= 1'b0;
    end else begin
      sr_rst_q  <= 1'b0;
      ns_load_q <= 1'b0;
      ns_out_q  <= 1'b0;
      found_l_q <= found_l_d;
      // Idle-gap counter only runs while a frame is open.
      if (!in_frame || rx_valid) tmo_q <= '0;
      else                       tmo_q <= tmo_q + 1'b1;

      if (tmo_hit) begin
        err_q   <= sat_inc8(err_q);
        state_q <= ST_IDLE;
      end else begin
        case (state_q)
          ST_IDLE: begin
            if (rx_valid && rx_data == SYNC_BYTE) state_q <= ST_CMD;
          end
          ST_CMD: begin
            if (rx_valid) begin
              chk_q <= rx_data;
              if (rx_data == CMD_JOB) begin
                is_job_q    <= 1'b1;
                sr_rst_q    <= 1'b1;
                job_valid_q <= 1'b0;
                pay_cnt_q   <= PAY_LAST;
                state_q     <= ST_PAYLOAD;
              end else if (rx_data == CMD_READ) begin
                is_job_q <= 1'b0;
                state_q  <= ST_CHK;
              end else begin
                state_q <= ST_IDLE;
              end
            end
          end
          ST_PAYLOAD: begin
            if (rx_valid) begin
              chk_q <= chk_q ^ rx_data;
              if (pay_cnt_q == '0) state_q <= ST_CHK;
              else                 pay_cnt_q <= pay_cnt_q - 1'b1;
            end
          end
          ST_CHK: begin
            if (rx_valid) begin
              if (rx_data != chk_q) begin
                err_q   <= sat_inc8(err_q);
                state_q <= ST_IDLE;
              end else if (is_job_q) begin
                job_valid_q <= 1'b1;
                state_q     <= ST_IDLE;
              end else begin
                ns_load_q <= 1'b1;
                state_q   <= ST_NS_LOAD;
              end
            end
          end
          ST_NS_LOAD: begin
            tx_valid_q <= 1'b1;
            tx_data_q  <= {7'b0, found_l_q};
            state_q    <= ST_TX_STAT;
          end
          ST_TX_STAT: begin
            // ns_data has settled since the ns_load edge; present it next.
            if (tx_ready) begin
              tx_data_q <= ns_data;
              nleft_q   <= NONCE_LAST;
              state_q   <= ST_TX_BYTE;
            end
          end
          ST_TX_BYTE: begin
            if (tx_ready) begin
              tx_valid_q <= 1'b0;
              ns_out_q   <= 1'b1;
              state_q    <= ST_NS_SHIFT;
            end
          end
          ST_NS_SHIFT: begin
            // The register shifted on the ns_out rising edge at the start of
            // this cycle, so ns_data is the next byte by the end of it.
            if (nleft_q == '0) begin
              state_q <= ST_IDLE;
            end else begin
              nleft_q    <= nleft_q - 1'b1;
              tx_valid_q <= 1'b1;
              tx_data_q  <= ns_data;
              state_q    <= ST_TX_BYTE;
            end
          end
          default: state_q <= ST_IDLE;
        endcase
      end
    end
  end

  strobe_gen u_strobe_gen (
    .clk    (clk),
    .rst    (rst),
    .data_i (rx_data),
    .load_i (sg_load),
    .data_o (sr_data),
    .load_o (sr_load)
  );

  assign tx_data   = tx_data_q;
  assign tx_valid  = tx_valid_q;
  assign sr_rst    = sr_rst_q;
  assign job_valid = job_valid_q;
  assign ns_load   = ns_load_q;
  assign ns_out    = ns_out_q;
  assign err_cnt   = err_q;

endmodule

// File: tb/tb_miner_host_ctrl.sv
// Directed bench for miner_host_ctrl with a behavioural nonce shift register.
// Latency: n/a.
// Backpressure: tx_ready stalled for 5 cycles on the third response byte.
module tb_miner_host_ctrl;

  localparam int TMO = 100;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] rx_data = 8'h00;
  logic       rx_valid = 1'b0;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready = 1'b1;
  logic [7:0] sr_data;
  logic       sr_load;
  logic       sr_rst;
  logic       job_valid;
  logic       found = 1'b0;
  logic       ns_load;
  logic       ns_out;
  logic [7:0] ns_data;
  logic [7:0] err_cnt;

  miner_host_ctrl #(.TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .rst(rst), .rx_data(rx_data), .rx_valid(rx_valid),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .sr_data(sr_data), .sr_load(sr_load), .sr_rst(sr_rst), .job_valid(job_valid),
    .found(found), .ns_load(ns_load), .ns_out(ns_out), .ns_data(ns_data),
    .err_cnt(err_cnt)
  );

  always #5 clk = ~clk;

  // Edge-clocked nonce register: loads on ns_load rise, shifts on ns_out rise.
  logic [63:0] nreg = 64'h0;
  always @(posedge ns_load or posedge ns_out) begin
    if (ns_load) nreg <= 64'h0123456789ABCDEF;
    else         nreg <= {nreg[55:0], 8'h00};
  end
  assign ns_data = nreg[63:56];

  int total = 0;
  int bad = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Expected sr_load/sr_data: two cycles after each payload byte the bench marks.
  logic       pay_mark = 1'b0;
  logic [1:0] hist;
  logic [7:0] dhist [2];
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      hist     <= 2'b00;
      dhist[0] <= 8'h00;
      dhist[1] <= 8'h00;
    end else begin
      hist     <= {hist[0], rx_valid & pay_mark};
      dhist[0] <= rx_data;
      dhist[1] <= dhist[0];
    end
  end

  logic [7:0] txq[$];
  logic [7:0] held = 8'h00;
  int stall_n = 0;
  int stable_bad = 0;
  int strobe_bad = 0;
  int sr_load_cnt = 0, sr_rst_cnt = 0, ns_load_cnt = 0, ns_out_cnt = 0;
  logic prev_hs = 1'b0, prev_ns_load = 1'b0, prev_ns_out = 1'b0;

  always @(negedge clk) begin
    logic hs;
    if (tx_valid && txq.size() == 2 && stall_n < 5) begin
      if (stall_n > 0 && tx_data !== held) stable_bad++;
      held = tx_data;
      stall_n++;
      tx_ready = 1'b0;
    end else if (tx_valid && txq.size() == 2 && stall_n == 5) begin
      if (tx_data !== held) stable_bad++;
      stall_n = 6;
      tx_ready = 1'b1;
    end else begin
      tx_ready = 1'b1;
    end
    hs = tx_valid && tx_ready;
    if (hs) txq.push_back(tx_data);

    if (sr_load !== hist[1]) strobe_bad++;
    if (sr_load && sr_data !== dhist[1]) strobe_bad++;
    if (ns_load && tx_valid) strobe_bad++;
    if (prev_ns_load && !tx_valid) strobe_bad++;
    if (ns_out && !prev_hs) strobe_bad++;
    if (prev_ns_out && (ns_out_cnt % 8 != 0) && !tx_valid) strobe_bad++;

    sr_load_cnt += int'(sr_load);
    sr_rst_cnt  += int'(sr_rst);
    ns_load_cnt += int'(ns_load);
    ns_out_cnt  += int'(ns_out);
    prev_hs      = hs;
    prev_ns_load = ns_load;
    prev_ns_out  = ns_out;
  end

  function automatic logic [7:0] pat(input int mode, input int i);
    if (mode == 0) return 8'h00;
    return 8'(i * 37 + 5);
  endfunction

  function automatic logic [7:0] good_chk(input int mode);
    logic [7:0] c = 8'h01;
    for (int i = 0; i < 80; i++) c = c ^ pat(mode, i);
    return c;
  endfunction

  task automatic pulse_byte(input logic [7:0] b, input logic mark);
    @(negedge clk);
    rx_data = b; rx_valid = 1'b1; pay_mark = mark;
    @(negedge clk);
    rx_valid = 1'b0; pay_mark = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input logic mark);
    pulse_byte(b, mark);
    repeat (2) @(negedge clk);
  endtask

  task automatic send_job(input int mode, input logic [7:0] chk, input logic exp_ok);
    send_byte(8'hA5, 1'b0);
    send_byte(8'h01, 1'b0);
    for (int i = 0; i < 80; i++) send_byte(pat(mode, i), 1'b1);
    @(negedge clk);
    rx_data = chk; rx_valid = 1'b1;
    check("jv_before_chk", job_valid, 1'b0);
    @(negedge clk);
    rx_valid = 1'b0;
    check("jv_after_chk", job_valid, exp_ok);
    repeat (2) @(negedge clk);
  endtask

  task automatic wait_tx(input int n);
    for (int c = 0; c < 300 && txq.size() < n; c++) @(negedge clk);
    check("tx_count", txq.size(), n);
  endtask

  int l0, r0, nl0, no0;
  logic [7:0] exp_rd [9] = '{8'h01, 8'h01, 8'h23, 8'h45, 8'h67, 8'h89, 8'hAB, 8'hCD, 8'hEF};

  initial begin
    repeat (3) @(negedge clk);
    check("reset_outs", {tx_valid, tx_data, sr_data, sr_load, sr_rst, job_valid, ns_load, ns_out, err_cnt}, 30'h0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // good job, all-zero payload
    send_job(0, 8'h01, 1'b1);
    check("job1_loads", sr_load_cnt, 80);
    check("job1_srrst", sr_rst_cnt, 1);
    check("job1_err", err_cnt, 8'h00);

    // bad checksum
    send_job(0, 8'h00, 1'b0);
    check("badchk_err", err_cnt, 8'h01);
    check("badchk_loads", sr_load_cnt, 160);
    check("badchk_srrst", sr_rst_cnt, 2);

    // read with found pulsed earlier
    @(negedge clk); found = 1'b1;
    @(negedge clk); found = 1'b0;
    nl0 = ns_load_cnt; no0 = ns_out_cnt;
    txq.delete();
    send_byte(8'hA5, 1'b0); send_byte(8'h02, 1'b0); send_byte(8'h02, 1'b0);
    wait_tx(9);
    for (int i = 0; i < 9 && i < txq.size(); i++) check($sformatf("rd_byte%0d", i), txq[i], exp_rd[i]);
    repeat (4) @(negedge clk);
    check("rd_nsload", ns_load_cnt - nl0, 1);
    check("rd_nsout", ns_out_cnt - no0, 8);
    check("rd_stalled", stall_n, 6);
    check("rd_stable", stable_bad, 0);
    check("rd_timing", strobe_bad, 0);

    // second read: found_l was cleared by the first
    txq.delete();
    send_byte(8'hA5, 1'b0); send_byte(8'h02, 1'b0); send_byte(8'h02, 1'b0);
    wait_tx(9);
    if (txq.size() >= 2) begin
      check("rd2_status", txq[0], 8'h00);
      check("rd2_first", txq[1], 8'h01);
    end
    repeat (4) @(negedge clk);

    // timeout mid-payload, then a good job
    l0 = sr_load_cnt;
    send_byte(8'hA5, 1'b0); send_byte(8'h01, 1'b0);
    for (int i = 0; i < 10; i++) send_byte(pat(1, i), 1'b1);
    repeat (TMO + 20) @(negedge clk);
    check("tmo_err", err_cnt, 8'h02);
    check("tmo_jv", job_valid, 1'b0);
    send_job(1, good_chk(1), 1'b1);
    check("tmo_loads", sr_load_cnt - l0, 90);
    check("tmo_err_after", err_cnt, 8'h02);

    // reset at payload byte 40
    send_byte(8'hA5, 1'b0); send_byte(8'h01, 1'b0);
    for (int i = 0; i < 39; i++) send_byte(pat(1, i), 1'b1);
    pulse_byte(pat(1, 39), 1'b1);
    rst = 1'b1;
    @(negedge clk);
    check("midrst_outs", {tx_valid, tx_data, sr_data, sr_load, sr_rst, job_valid, ns_load, ns_out, err_cnt}, 30'h0);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    send_job(1, good_chk(1), 1'b1);

    // garbage bytes
    l0 = sr_load_cnt; r0 = sr_rst_cnt; nl0 = ns_load_cnt;
    send_byte(8'h00, 1'b0); send_byte(8'hFF, 1'b0); send_byte(8'hA5, 1'b0);
    send_byte(8'h7E, 1'b0); send_byte(8'h00, 1'b0);
    repeat (4) @(negedge clk);
    check("garb_strobes", (sr_load_cnt - l0) + (sr_rst_cnt - r0) + (ns_load_cnt - nl0), 0);
    check("garb_err", err_cnt, 8'h00);

    // 300 checksum errors via bad read frames
    for (int i = 0; i < 300; i++) begin
      send_byte(8'hA5, 1'b0); send_byte(8'h02, 1'b0); send_byte(8'h00, 1'b0);
      if (i == 253) check("err_254", err_cnt, 8'hFE);
    end
    check("err_sat", err_cnt, 8'hFF);
    check("strobe_timing", strobe_bad, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
